fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch and step sequencer feeding the decode block; producer of its ir/state inputs, consumer of nstate/defined.
//  Fetches 32-bit instruction words over a Wishbone-style instruction port, latches IR and steps state_o from decode's nstate.
//  Owns the PC: sequential increment, decode-requested PC loads, and traps on illegal instruction, bus error or misaligned target.
// PARAMETERS
//  XLEN          64                     PC / address width
//  RESET_VECTOR  64'hFFFF_FFFF_FFFF_FF00 PC after reset
//  TRAP_VECTOR   64'hFFFF_FFFF_FFFF_FE00 PC loaded on any trap
// PORTS
//  clk_i      in   1     clock, rising edge
//  reset_i    in   1     reset; asynchronous, active-low
//  iadr_o     out  XLEN  fetch address (= pc_o while icyc_o)
//  icyc_o     out  1     bus cycle in progress
//  istb_o     out  1     strobe; equal to icyc_o
//  iack_i     in   1     fetch data valid on idat_i
//  ierr_i     in   1     fetch bus error
//  idat_i     in   32    fetched instruction word
//  ir_o       out  32    instruction register to decode
//  state_o    out  3     execution step to decode
//  exec_o     out  1     high while in EXEC; datapath enables gated by it
//  nstate_i   in   3     next step from decode
//  defined_i  in   1     decode recognises ir_o
//  pc_we_i    in   1     decode requests PC load (branch/jump)
//  pc_d_i     in   XLEN  PC load value
//  pc_o       out  XLEN  current PC
//  trap_o     out  1     one-cycle pulse in TRAP
//  cause_o    out  2     0 none, 1 illegal, 2 bus error, 3 misaligned; held until next trap
// BEHAVIOUR
//  FSM: RESET -> FETCH -> EXEC -> FETCH ...; EXEC/FETCH -> TRAP -> FETCH.
//  Reset (reset_i low, async): fsm=RESET, pc_o=RESET_VECTOR, ir_o=32'h0000_0013 (NOP),
//   state_o=0, icyc_o=istb_o=0, exec_o=0, trap_o=0, cause_o=0, npc=RESET_VECTOR+4.
//  RESET: exactly one cycle after reset_i rises, then FETCH.
//  FETCH: icyc_o=istb_o=1, iadr_o=pc_o held stable until iack_i or ierr_i.
//   iack_i: ir_o<=idat_i, state_o<=0, npc<=pc_o+4, drop cyc/stb same edge, -> EXEC.
//   ierr_i (wins over simultaneous iack_i): ir_o unchanged, cause 2, -> TRAP.
//  EXEC: exec_o=1; each edge state_o<=nstate_i.
//   defined_i==0 in any EXEC cycle: cause 1, -> TRAP (takes priority over pc_we_i/completion).
//   pc_we_i: npc<=pc_d_i; pc_d_i[1:0]!=0 -> cause 3, -> TRAP instead. Last write wins.
//   completion when nstate_i==state_o (decode self-loop): pc_o<=npc, -> FETCH.
//   pc_we_i on the completing cycle: pc_o<=pc_d_i directly (bypasses npc).
//  TRAP: one cycle; trap_o=1, pc_o<=TRAP_VECTOR, state_o<=0, npc<=TRAP_VECTOR+4, -> FETCH.
//  PC arithmetic modulo 2^XLEN (pc+4 wraps to 0 silently, not a trap).
//  Minimum latency: FETCH 1 cycle with same-cycle ack; ADDI (steps 0,1,2,3) = 4 EXEC cycles.
//  Reset mid-fetch abandons the bus cycle immediately (icyc_o low asynchronously).
// STRUCTURE
//  seq_defs.vh: FSM state encodings, cause codes, NOP constant, vector defaults.
//  Sub-module next_pc: npc register, pc+4 adder, pc_d_i bypass and alignment check.
//  Top: FSM, IR/state registers, bus outputs.
// TESTING
//  Reset: reset_i low mid-run -> pc_o=RESET_VECTOR, ir_o=0000_0013, icyc_o=0;
//   one cycle after release icyc_o=1, iadr_o=FFFF_FFFF_FFFF_FF00.
//  ADDI X1,X0,$042 (0420_0093) acked with 2 wait states -> ir_o=0420_0093, state_o 0,1,2,3,
//   then FETCH at RESET_VECTOR+4.
//  Undefined word, defined_i=0 at step 0 -> trap_o pulse, cause_o=1, next iadr_o=TRAP_VECTOR.
//  pc_we_i with pc_d_i=...1000 at step 1, complete at step 2 -> next fetch 0x...1000;
//   pc_d_i=...1002 -> cause_o=3.
//  iack_i and ierr_i together -> cause_o=2, ir_o unchanged, refetch from TRAP_VECTOR.
//  pc_o=FFFF_FFFF_FFFF_FFFC, sequential completion -> next iadr_o=0, no trap.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared FSM states, cause codes and vector defaults for the fetch sequencer
package fetch_sequencer_pkg;

   localparam int          XLEN_DEF         = 64;
   localparam logic [63:0] RESET_VECTOR_DEF = 64'hFFFF_FFFF_FFFF_FF00;
   localparam logic [63:0] TRAP_VECTOR_DEF  = 64'hFFFF_FFFF_FFFF_FE00;

   // ADDI x0,x0,0: a harmless word for decode to see before the first fetch lands
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   localparam logic [1:0] CAUSE_NONE     = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
   localparam logic [1:0] CAUSE_BUS_ERR  = 2'd2;
   localparam logic [1:0] CAUSE_MISALIGN = 2'd3;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_TRAP  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - Wishbone-style instruction fetch port
interface fetch_sequencer_if #(
   parameter int XLEN = 64
) ();

   logic [XLEN-1:0] iadr_o;
   logic            icyc_o;
   logic            istb_o;
   logic            iack_i;
   logic            ierr_i;
   logic [31:0]     idat_i;

   // master is the sequencer, slave is the instruction memory
   modport master (
      output iadr_o, icyc_o, istb_o,
      input  iack_i, ierr_i, idat_i
   );

   modport slave (
      input  iadr_o, icyc_o, istb_o,
      output iack_i, ierr_i, idat_i
   );

endinterface

// File: rtl/fetch_sequencer_next_pc.sv
// rtl/fetch_sequencer_next_pc.sv - next-PC register, pc+4 adder, redirect bypass and alignment check
module fetch_sequencer_next_pc
   import fetch_sequencer_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_pc_d,
   input  logic            i_pc_we,
   input  logic            i_seq_load,
   input  logic            i_redirect_we,
   input  logic            i_trap_load,
   output logic [XLEN-1:0] o_target,
   output logic            o_misaligned
);

   logic [XLEN-1:0] r_npc;
   logic [XLEN-1:0] w_pc_plus4;

   // wraps modulo 2^XLEN on purpose; running off the top of memory is not a trap
   assign w_pc_plus4 = i_pc + XLEN'(4);

   // a redirect on the completing cycle must reach the PC without waiting for r_npc
   assign o_target     = i_pc_we ? i_pc_d : r_npc;
   assign o_misaligned = |i_pc_d[1:0];

   // npc tracks where execution continues once the current instruction completes
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_npc <= RESET_VECTOR + XLEN'(4);
      end else if (i_trap_load) begin
         r_npc <= TRAP_VECTOR + XLEN'(4);
      end else if (i_seq_load) begin
         r_npc <= w_pc_plus4;
      end else if (i_redirect_we) begin
         r_npc <= i_pc_d;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch and step sequencer feeding decode
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   fetch_sequencer_if.master ibus,
   output logic [31:0]       ir_o,
   output logic [2:0]        state_o,
   output logic              exec_o,
   input  logic [2:0]        nstate_i,
   input  logic              defined_i,
   input  logic              pc_we_i,
   input  logic [XLEN-1:0]   pc_d_i,
   output logic [XLEN-1:0]   pc_o,
   output logic              trap_o,
   output logic [1:0]        cause_o
);

   seq_state_e      r_fsm;
   seq_state_e      w_fsm_nxt;
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_ir;
   logic [2:0]      r_state;
   logic [1:0]      r_cause;

   logic            w_take_trap;
   logic [1:0]      w_trap_cause;
   logic            w_ir_load;
   logic            w_pc_load;
   logic [XLEN-1:0] w_pc_nxt;
   logic [2:0]      w_state_nxt;
   logic            w_npc_we;
   logic            w_in_trap;
   logic [XLEN-1:0] w_target;
   logic            w_misaligned;

   assign w_in_trap = (r_fsm == S_TRAP);

   fetch_sequencer_next_pc #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RESET_VECTOR),
      .TRAP_VECTOR  (TRAP_VECTOR)
   ) u_next_pc (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .i_pc          (r_pc),
      .i_pc_d        (pc_d_i),
      .i_pc_we       (pc_we_i),
      .i_seq_load    (w_ir_load),
      .i_redirect_we (w_npc_we),
      .i_trap_load   (w_in_trap),
      .o_target      (w_target),
      .o_misaligned  (w_misaligned)
   );

   // state register; reset drops the bus cycle asynchronously via the decoded outputs
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) r_fsm <= S_RESET;
      else          r_fsm <= w_fsm_nxt;
   end

   // next-state and datapath controls; illegal beats misaligned beats completion in EXEC
   always_comb begin
      w_fsm_nxt    = r_fsm;
      w_take_trap  = 1'b0;
      w_trap_cause = CAUSE_NONE;
      w_ir_load    = 1'b0;
      w_pc_load    = 1'b0;
      w_pc_nxt     = r_pc;
      w_state_nxt  = r_state;
      w_npc_we     = 1'b0;
      case (r_fsm)
         S_RESET: w_fsm_nxt = S_FETCH;
         S_FETCH: begin
            if (ibus.ierr_i) begin
               w_take_trap  = 1'b1;
               w_trap_cause = CAUSE_BUS_ERR;
            end else if (ibus.iack_i) begin
               w_ir_load   = 1'b1;
               w_state_nxt = 3'd0;
               w_fsm_nxt   = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = nstate_i;
            if (!defined_i) begin
               w_take_trap  = 1'b1;
               w_trap_cause = CAUSE_ILLEGAL;
            end else if (pc_we_i && w_misaligned) begin
               w_take_trap  = 1'b1;
               w_trap_cause = CAUSE_MISALIGN;
            end else begin
               w_npc_we = pc_we_i;
               // decode signals completion by holding its step
               if (nstate_i == r_state) begin
                  w_pc_load = 1'b1;
                  w_pc_nxt  = w_target;
                  w_fsm_nxt = S_FETCH;
               end
            end
         end
         S_TRAP: begin
            w_pc_load   = 1'b1;
            w_pc_nxt    = TRAP_VECTOR;
            w_state_nxt = 3'd0;
            w_fsm_nxt   = S_FETCH;
         end
         default: w_fsm_nxt = S_RESET;
      endcase
      if (w_take_trap) w_fsm_nxt = S_TRAP;
   end

   // PC, IR, step and cause registers; cause is sticky until the next trap
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_pc    <= RESET_VECTOR;
         r_ir    <= NOP_INSN;
         r_state <= 3'd0;
         r_cause <= CAUSE_NONE;
      end else begin
         if (w_pc_load)   r_pc    <= w_pc_nxt;
         if (w_ir_load)   r_ir    <= ibus.idat_i;
         r_state <= w_state_nxt;
         if (w_take_trap) r_cause <= w_trap_cause;
      end
   end

   assign ibus.icyc_o = (r_fsm == S_FETCH);
   assign ibus.istb_o = (r_fsm == S_FETCH);
   assign ibus.iadr_o = r_pc;
   assign exec_o      = (r_fsm == S_EXEC);
   assign trap_o      = w_in_trap;
   assign ir_o        = r_ir;
   assign state_o     = r_state;
   assign pc_o        = r_pc;
   assign cause_o     = r_cause;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

   localparam logic [63:0] RV  = 64'hFFFF_FFFF_FFFF_FF00;
   localparam logic [63:0] TV  = 64'hFFFF_FFFF_FFFF_FE00;
   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam int MD_RESET = 0;
   localparam int MD_FETCH = 1;
   localparam int MD_EXEC  = 2;
   localparam int MD_TRAP  = 3;

   logic        clk;
   logic        rst_n;
   logic [2:0]  nstate;
   logic        defined;
   logic        pc_we;
   logic [63:0] pc_d;
   logic [31:0] ir;
   logic [2:0]  state;
   logic        exec;
   logic [63:0] pc;
   logic        trap;
   logic [1:0]  cause;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   fetch_sequencer_if #(.XLEN(64)) ibus_if ();

   fetch_sequencer dut (
      .clk_i     (clk),
      .reset_i   (rst_n),
      .ibus      (ibus_if),
      .ir_o      (ir),
      .state_o   (state),
      .exec_o    (exec),
      .nstate_i  (nstate),
      .defined_i (defined),
      .pc_we_i   (pc_we),
      .pc_d_i    (pc_d),
      .pc_o      (pc),
      .trap_o    (trap),
      .cause_o   (cause)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: what each rule says the sequencer must hold after every edge
   int          m_mode;
   logic [63:0] m_pc;
   logic [63:0] m_npc;
   logic [31:0] m_ir;
   logic [2:0]  m_st;
   logic [1:0]  m_cause;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode  <= MD_RESET;
         m_pc    <= RV;
         m_npc   <= RV + 64'd4;
         m_ir    <= NOP;
         m_st    <= 3'd0;
         m_cause <= 2'd0;
      end else begin
         case (m_mode)
            MD_RESET: m_mode <= MD_FETCH;
            MD_FETCH: begin
               if (ibus_if.ierr_i) begin
                  m_cause <= 2'd2;
                  m_mode  <= MD_TRAP;
               end else if (ibus_if.iack_i) begin
                  m_ir   <= ibus_if.idat_i;
                  m_st   <= 3'd0;
                  m_npc  <= m_pc + 64'd4;
                  m_mode <= MD_EXEC;
               end
            end
            MD_EXEC: begin
               m_st <= nstate;
               if (!defined) begin
                  m_cause <= 2'd1;
                  m_mode  <= MD_TRAP;
               end else if (pc_we && pc_d[1:0] != 2'b00) begin
                  m_cause <= 2'd3;
                  m_mode  <= MD_TRAP;
               end else begin
                  if (pc_we) m_npc <= pc_d;
                  if (nstate == m_st) begin
                     m_pc   <= pc_we ? pc_d : m_npc;
                     m_mode <= MD_FETCH;
                  end
               end
            end
            default: begin
               m_pc   <= TV;
               m_npc  <= TV + 64'd4;
               m_st   <= 3'd0;
               m_mode <= MD_FETCH;
            end
         endcase
      end
   end

   // cycle-by-cycle comparison on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("icyc",  ibus_if.icyc_o, 64'(m_mode == MD_FETCH));
         check("istb",  ibus_if.istb_o, 64'(m_mode == MD_FETCH));
         check("exec",  exec,  64'(m_mode == MD_EXEC));
         check("trap",  trap,  64'(m_mode == MD_TRAP));
         check("pc",    pc,    m_pc);
         check("ir",    ir,    64'(m_ir));
         check("state", state, 64'(m_st));
         check("cause", cause, 64'(m_cause));
         if (m_mode == MD_FETCH) check("iadr", ibus_if.iadr_o, m_pc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ibus_if.iack_i = 1'b0;
      ibus_if.ierr_i = 1'b0;
      ibus_if.idat_i = 32'h0;
      nstate  = 3'd0;
      defined = 1'b1;
      pc_we   = 1'b0;
      pc_d    = 64'h0;
   endtask

   task automatic fetch(input int waits, input logic [31:0] word);
      for (int i = 0; i < waits; i++) tick();
      ibus_if.iack_i = 1'b1;
      ibus_if.idat_i = word;
      tick();
      idle();
   endtask

   task automatic step(input logic [2:0] ns, input logic def, input logic we, input logic [63:0] d);
      nstate  = ns;
      defined = def;
      pc_we   = we;
      pc_d    = d;
      tick();
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_pc", pc, RV);
      check("rst_ir", ir, 64'(NOP));
      check("rst_icyc", ibus_if.icyc_o, 64'd0);
      rst_n = 1'b1;
      check("reset_hold_icyc", ibus_if.icyc_o, 64'd0);
      tick();
      check("first_icyc", ibus_if.icyc_o, 64'd1);
      check("first_iadr", ibus_if.iadr_o, 64'hFFFF_FFFF_FFFF_FF00);

      // ADDI x1,x0,0x42 with two wait states, steps 0..3
      fetch(2, 32'h0420_0093);
      check("addi_ir", ir, 64'h0420_0093);
      check("addi_s0", state, 64'd0);
      check("addi_exec", exec, 64'd1);
      step(3'd1, 1'b1, 1'b0, 64'h0);
      check("addi_s1", state, 64'd1);
      step(3'd2, 1'b1, 1'b0, 64'h0);
      check("addi_s2", state, 64'd2);
      step(3'd3, 1'b1, 1'b0, 64'h0);
      check("addi_s3", state, 64'd3);
      step(3'd3, 1'b1, 1'b0, 64'h0);
      check("addi_next_iadr", ibus_if.iadr_o, 64'hFFFF_FFFF_FFFF_FF04);

      // undefined word traps on step 0
      fetch(0, 32'hFFFF_FFFF);
      step(3'd0, 1'b0, 1'b0, 64'h0);
      check("ill_trap", trap, 64'd1);
      check("ill_cause", cause, 64'd1);
      tick();
      check("ill_trap_gone", trap, 64'd0);
      check("ill_iadr", ibus_if.iadr_o, 64'hFFFF_FFFF_FFFF_FE00);

      // redirect at step 1, completion at step 2
      fetch(0, 32'h0000_0063);
      step(3'd1, 1'b1, 1'b0, 64'h0);
      step(3'd2, 1'b1, 1'b1, 64'h0000_0000_0000_1000);
      step(3'd2, 1'b1, 1'b0, 64'h0);
      check("br_iadr", ibus_if.iadr_o, 64'h0000_0000_0000_1000);

      // misaligned redirect
      fetch(0, 32'h0000_0067);
      step(3'd1, 1'b1, 1'b1, 64'h0000_0000_0000_1002);
      check("mis_trap", trap, 64'd1);
      check("mis_cause", cause, 64'd3);
      tick();

      // ack and error together: error wins, IR untouched
      ibus_if.iack_i = 1'b1;
      ibus_if.ierr_i = 1'b1;
      ibus_if.idat_i = 32'hDEAD_BEEF;
      tick();
      idle();
      check("berr_cause", cause, 64'd2);
      check("berr_ir", ir, 64'h0000_0067);
      check("berr_trap", trap, 64'd1);
      tick();
      check("berr_iadr", ibus_if.iadr_o, 64'hFFFF_FFFF_FFFF_FE00);

      // redirect on the completing cycle lands directly, then pc+4 wraps to 0
      fetch(0, 32'h0000_0013);
      step(3'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      check("byp_iadr", ibus_if.iadr_o, 64'hFFFF_FFFF_FFFF_FFFC);
      fetch(0, 32'h0000_0013);
      step(3'd0, 1'b1, 1'b0, 64'h0);
      check("wrap_iadr", ibus_if.iadr_o, 64'h0);
      check("wrap_trap", trap, 64'd0);
      check("wrap_cause", cause, 64'd2);

      // two redirects in one instruction: the later one wins
      fetch(0, 32'h0000_0013);
      step(3'd1, 1'b1, 1'b1, 64'h0000_0000_0000_2000);
      step(3'd2, 1'b1, 1'b1, 64'h0000_0000_0000_3000);
      step(3'd2, 1'b1, 1'b0, 64'h0);
      check("lww_iadr", ibus_if.iadr_o, 64'h0000_0000_0000_3000);

      // reset in the middle of a fetch cycle
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_icyc", ibus_if.icyc_o, 64'd0);
      check("mid_rst_pc", pc, 64'hFFFF_FFFF_FFFF_FF00);
      check("mid_rst_ir", ir, 64'h0000_0013);
      check("mid_rst_cause", cause, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rel_icyc", ibus_if.icyc_o, 64'd1);
      check("rel_iadr", ibus_if.iadr_o, 64'hFFFF_FFFF_FFFF_FF00);
      tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
